// File: rtl/lock_pkg.sv
// Shared encodings for the digital lock: FSM states, checker compare types, keypad command keys.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED     = 3'd0,
        ST_CHECK_UC   = 3'd1,
        ST_UNLOCKED   = 3'd2,
        ST_NEW_UC     = 3'd3,
        ST_CONFIRM_UC = 3'd4,
        ST_COMMIT     = 3'd5,
        ST_PC_ENTRY   = 3'd6,
        ST_LOCKOUT    = 3'd7
    } lock_state_e;

    localparam logic [1:0] CMP_PC      = 2'b00;
    localparam logic [1:0] CMP_UC      = 2'b01;
    localparam logic [1:0] CMP_ENTRY   = 2'b10;
    localparam logic [1:0] CMP_CAPTURE = 2'b11;

    localparam logic [3:0] KEY_MODE   = 4'd7;
    localparam logic [3:0] KEY_SUBMIT = 4'd8;
    localparam logic [3:0] KEY_CLEAR  = 4'd9;

endpackage

// File: rtl/lock_timer.sv
// Loadable saturating down-counter; done_o is high for the single cycle the count sits at 1,
// so a load of N yields done N-1 cycles after the load edge and the owner acts on the Nth edge.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         hwclk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Top-level lock control FSM sequencing the code checker. Optional UNLOCKED auto-relock
// timeout is built only when LOCK_SEQ_AUTO_RELOCK_EN is defined.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int          CHECK_WAIT     = 2,
    parameter int          MAX_FAILS      = 3,
    parameter logic [23:0] LOCKOUT_CYCLES = 24'd12_000_000
`ifdef LOCK_SEQ_AUTO_RELOCK_EN
    ,
    parameter logic [27:0] RELOCK_CYCLES  = 28'd120_000_000
`endif
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       key_valid_i,
    input  logic [3:0] key_i,
    input  logic       correct_i,
    output logic       read_input_o,
    output logic [1:0] compare_type_o,
    output logic       store_o,
    output logic       unlocked_o,
    output logic       lockout_o,
    output logic       error_o,
    output logic [2:0] state_o
);

    localparam int WAIT_W = $clog2(CHECK_WAIT + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    lock_state_e       state_q, state_d;
    logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
    logic              err_q, err_d, busy_q, busy_d;
    logic              rd_q, rd_d, store_q, store_d, unl_q, unl_d, lko_q, lko_d, errout_q;
    logic [1:0]        cmp_q, cmp_d;
    logic [2:0]        st_out_q;
    logic              wait_load, wait_done, lock_load, lock_done;
    logic              k_submit, k_mode, k_clear;

    assign k_submit = key_valid_i && (key_i == KEY_SUBMIT);
    assign k_mode   = key_valid_i && (key_i == KEY_MODE);
    assign k_clear  = key_valid_i && (key_i == KEY_CLEAR);
    assign fail_inc = (fail_q == FAIL_W'(MAX_FAILS)) ? fail_q : fail_q + FAIL_W'(1);

    lock_timer #(.W(WAIT_W)) u_wait (
        .hwclk(hwclk), .reset(reset), .load_i(wait_load),
        .load_val_i(WAIT_W'(CHECK_WAIT)), .done_o(wait_done)
    );

    lock_timer #(.W(24)) u_lockout (
        .hwclk(hwclk), .reset(reset), .load_i(lock_load),
        .load_val_i(LOCKOUT_CYCLES), .done_o(lock_done)
    );

`ifdef LOCK_SEQ_AUTO_RELOCK_EN
    logic relock_load, relock_done;

    lock_timer #(.W(28)) u_relock (
        .hwclk(hwclk), .reset(reset), .load_i(relock_load),
        .load_val_i(RELOCK_CYCLES), .done_o(relock_done)
    );

    // Restart on UNLOCKED entry and on every key seen while unlocked.
    assign relock_load = (state_d == ST_UNLOCKED) && ((state_q != ST_UNLOCKED) || key_valid_i);
`endif

    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        err_d     = key_valid_i ? 1'b0 : err_q;
        busy_d    = busy_q;
        wait_load = 1'b0;
        rd_d      = 1'b0;
        cmp_d     = CMP_UC;
        case (state_q)
            ST_LOCKED: begin
                rd_d = 1'b1;
                if (k_submit) begin
                    state_d   = ST_CHECK_UC;
                    wait_load = 1'b1;
                end else if (k_mode) begin
                    state_d = ST_PC_ENTRY;
                end
            end
            ST_CHECK_UC: begin
                if (wait_done) begin
                    if (correct_i) begin
                        state_d = ST_UNLOCKED;
                        fail_d  = '0;
                    end else begin
                        err_d = 1'b1;
                        if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                            state_d = ST_LOCKOUT;
                            fail_d  = '0;
                        end else begin
                            state_d = ST_LOCKED;
                            fail_d  = fail_inc;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                rd_d = 1'b1;
                if (k_clear)
                    state_d = ST_LOCKED;
                else if (k_mode)
                    state_d = ST_NEW_UC;
`ifdef LOCK_SEQ_AUTO_RELOCK_EN
                else if (relock_done && !key_valid_i)
                    state_d = ST_LOCKED;
`endif
            end
            ST_NEW_UC: begin
                cmp_d = CMP_CAPTURE;
                rd_d  = !busy_q;
                if (busy_q) begin
                    if (wait_done) begin
                        busy_d  = 1'b0;
                        state_d = ST_CONFIRM_UC;
                    end
                end else if (k_submit) begin
                    busy_d    = 1'b1;
                    wait_load = 1'b1;
                end else if (k_clear) begin
                    state_d = ST_UNLOCKED;
                end
            end
            ST_CONFIRM_UC: begin
                cmp_d = CMP_ENTRY;
                rd_d  = !busy_q;
                if (busy_q) begin
                    if (wait_done) begin
                        busy_d  = 1'b0;
                        state_d = correct_i ? ST_COMMIT : ST_UNLOCKED;
                        if (!correct_i) err_d = 1'b1;
                    end
                end else if (k_submit) begin
                    busy_d    = 1'b1;
                    wait_load = 1'b1;
                end
            end
            ST_COMMIT: begin
                cmp_d   = CMP_ENTRY;
                state_d = ST_UNLOCKED;
            end
            ST_PC_ENTRY: begin
                cmp_d = CMP_PC;
                rd_d  = !busy_q;
                if (busy_q) begin
                    if (wait_done) begin
                        busy_d = 1'b0;
                        if (correct_i) begin
                            state_d = ST_NEW_UC;
                            fail_d  = '0;
                        end else begin
                            state_d = ST_LOCKED;
                            err_d   = 1'b1;
                        end
                    end
                end else if (k_submit) begin
                    busy_d    = 1'b1;
                    wait_load = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (lock_done) state_d = ST_LOCKED;
            end
        endcase
        lock_load = (state_d == ST_LOCKOUT) && (state_q != ST_LOCKOUT);
        unl_d     = (state_q == ST_UNLOCKED);
        lko_d     = (state_q == ST_LOCKOUT);
        store_d   = (state_q == ST_COMMIT);
    end

    // Outputs are registered off the current state, lagging it by one cycle.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_LOCKED;
            fail_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            rd_q     <= 1'b1;
            cmp_q    <= CMP_UC;
            store_q  <= 1'b0;
            unl_q    <= 1'b0;
            lko_q    <= 1'b0;
            errout_q <= 1'b0;
            st_out_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            rd_q     <= rd_d;
            cmp_q    <= cmp_d;
            store_q  <= store_d;
            unl_q    <= unl_d;
            lko_q    <= lko_d;
            errout_q <= err_q;
            st_out_q <= state_q;
        end
    end

    assign read_input_o   = rd_q;
    assign compare_type_o = cmp_q;
    assign store_o        = store_q;
    assign unlocked_o     = unl_q;
    assign lockout_o      = lko_q;
    assign error_o        = errout_q;
    assign state_o        = st_out_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with shortened lockout/relock counts.
module tb_lock_sequencer;

    logic       hwclk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid_i = 1'b0;
    logic [3:0] key_i = 4'd0;
    logic       correct_i = 1'b0;
    logic       read_input_o, store_o, unlocked_o, lockout_o, error_o;
    logic [1:0] compare_type_o;
    logic [2:0] state_o;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 hwclk = ~hwclk;

    lock_sequencer #(
        .CHECK_WAIT(2), .MAX_FAILS(3), .LOCKOUT_CYCLES(24'd20)
`ifdef LOCK_SEQ_AUTO_RELOCK_EN
        , .RELOCK_CYCLES(28'd100)
`endif
    ) dut (
        .hwclk(hwclk), .reset(reset), .key_valid_i(key_valid_i), .key_i(key_i),
        .correct_i(correct_i), .read_input_o(read_input_o), .compare_type_o(compare_type_o),
        .store_o(store_o), .unlocked_o(unlocked_o), .lockout_o(lockout_o),
        .error_o(error_o), .state_o(state_o)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid_i = 1'b1;
        key_i       = k;
        tick();
        key_valid_i = 1'b0;
    endtask

    task automatic do_unlock();
        correct_i = 1'b1;
        press(4'd8);
        tick(3);
    endtask

    task automatic wrong_submit();
        correct_i = 1'b0;
        press(4'd8);
        tick(3);
    endtask

    task automatic test_reset();
        tick(2);
        n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
        n_chk++; if (read_input_o !== 1'b1) begin n_fail++; $display("FAIL reset_read: got %b want 1", read_input_o); end
        n_chk++; if (compare_type_o !== 2'b01) begin n_fail++; $display("FAIL reset_cmp: got %b want 01", compare_type_o); end
        n_chk++; if ({store_o, unlocked_o, lockout_o, error_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {store_o, unlocked_o, lockout_o, error_o}); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_unlock();
        correct_i = 1'b1;
        press(4'd8);
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (compare_type_o !== 2'b01) begin n_fail++; $display("FAIL unlock_cmp%0d: got %b want 01", i, compare_type_o); end
            if (i == 2) begin
                n_chk++; if (unlocked_o !== 1'b0) begin n_fail++; $display("FAIL unlock_early: got %b want 0", unlocked_o); end
            end
            tick();
        end
        n_chk++; if (unlocked_o !== 1'b1) begin n_fail++; $display("FAIL unlock_on_time: got %b want 1", unlocked_o); end
        n_chk++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL unlock_state: got %0d want 2", state_o); end
    endtask

    task automatic test_new_uc();
        int stores;
        press(4'd7);
        tick();
        n_chk++; if (compare_type_o !== 2'b11) begin n_fail++; $display("FAIL newuc_cmp: got %b want 11", compare_type_o); end
        n_chk++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL newuc_state: got %0d want 3", state_o); end
        press(4'd8);
        tick();
        n_chk++; if (read_input_o !== 1'b0) begin n_fail++; $display("FAIL newuc_busy_read: got %b want 0", read_input_o); end
        n_chk++; if (compare_type_o !== 2'b11) begin n_fail++; $display("FAIL newuc_busy_cmp: got %b want 11", compare_type_o); end
        tick(2);
        n_chk++; if (compare_type_o !== 2'b10) begin n_fail++; $display("FAIL confirm_cmp: got %b want 10", compare_type_o); end
        n_chk++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL confirm_state: got %0d want 4", state_o); end
        correct_i = 1'b1;
        press(4'd8);
        stores = 0;
        for (int i = 0; i < 6; i++) begin
            if (store_o === 1'b1) stores++;
            tick();
        end
        n_chk++; if (stores !== 1) begin n_fail++; $display("FAIL store_pulse: got %0d cycles want 1", stores); end
        n_chk++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL commit_end_state: got %0d want 2", state_o); end
    endtask

    task automatic test_confirm_mismatch();
        press(4'd7);
        press(4'd8);
        tick(3);
        correct_i = 1'b0;
        press(4'd8);
        tick(3);
        n_chk++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL mismatch_state: got %0d want 2", state_o); end
        n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL mismatch_error: got %b want 1", error_o); end
        n_chk++; if (store_o !== 1'b0) begin n_fail++; $display("FAIL mismatch_store: got %b want 0", store_o); end
    endtask

    task automatic test_reset_mid_unlocked();
        reset = 1'b1;
        #1;
        n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d want 0", state_o); end
        n_chk++; if (unlocked_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_unlocked: got %b want 0", unlocked_o); end
        n_chk++; if (compare_type_o !== 2'b01) begin n_fail++; $display("FAIL rst_mid_cmp: got %b want 01", compare_type_o); end
        n_chk++; if ({store_o, error_o} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_flags: got %b want 00", {store_o, error_o}); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lockout();
        for (int i = 0; i < 2; i++) begin
            wrong_submit();
            n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL fail%0d_error: got %b want 1", i, error_o); end
            n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL fail%0d_state: got %0d want 0", i, state_o); end
        end
        wrong_submit();
        n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL fail2_error: got %b want 1", error_o); end
        n_chk++; if (lockout_o !== 1'b1 || state_o !== 3'd7) begin
            n_fail++; $display("FAIL lockout_entry: got lockout=%b state=%0d want 1/7", lockout_o, state_o); end
        correct_i = 1'b1;
        press(4'd8);
        tick(18);
        n_chk++; if (lockout_o !== 1'b1 || state_o !== 3'd7) begin
            n_fail++; $display("FAIL lockout_hold: got lockout=%b state=%0d want 1/7", lockout_o, state_o); end
        tick();
        n_chk++; if (lockout_o !== 1'b0 || state_o !== 3'd0) begin
            n_fail++; $display("FAIL lockout_exit: got lockout=%b state=%0d want 0/0", lockout_o, state_o); end
        wrong_submit();
        n_chk++; if (state_o !== 3'd0 || lockout_o !== 1'b0) begin
            n_fail++; $display("FAIL fail_cnt_cleared: got state=%0d lockout=%b want 0/0", state_o, lockout_o); end
        wrong_submit();
    endtask

    task automatic test_pc_override();
        correct_i = 1'b1;
        press(4'd7);
        tick();
        n_chk++; if (compare_type_o !== 2'b00 || state_o !== 3'd6) begin
            n_fail++; $display("FAIL pc_entry: got cmp=%b state=%0d want 00/6", compare_type_o, state_o); end
        press(4'd8);
        tick(3);
        n_chk++; if (state_o !== 3'd3 || compare_type_o !== 2'b11) begin
            n_fail++; $display("FAIL pc_to_newuc: got state=%0d cmp=%b want 3/11", state_o, compare_type_o); end
        press(4'd9);
        press(4'd9);
        tick(2);
        n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL pc_back_locked: got %0d want 0", state_o); end
        wrong_submit();
        n_chk++; if (state_o !== 3'd0 || lockout_o !== 1'b0) begin
            n_fail++; $display("FAIL pc_fail_cleared: got state=%0d lockout=%b want 0/0", state_o, lockout_o); end
    endtask

    task automatic test_relock();
        do_unlock();
`ifdef LOCK_SEQ_AUTO_RELOCK_EN
        tick(99);
        n_chk++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL relock_hold: got %0d want 2", state_o); end
        tick();
        n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL relock_fire: got %0d want 0", state_o); end
        do_unlock();
        tick(48);
        press(4'd3);
        tick(99);
        n_chk++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL relock_restart_hold: got %0d want 2", state_o); end
        tick();
        n_chk++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL relock_restart_edge: got %0d want 2", state_o); end
        tick();
        n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL relock_restart_fire: got %0d want 0", state_o); end
`else
        tick(300);
        n_chk++; if (state_o !== 3'd2 || unlocked_o !== 1'b1) begin
            n_fail++; $display("FAIL no_relock: got state=%0d unlocked=%b want 2/1", state_o, unlocked_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_new_uc();
        test_confirm_mismatch();
        test_reset_mid_unlocked();
        test_lockout();
        test_pc_override();
        test_relock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
